// File: rtl/fifo_sync_buf.sv
// Synchronous FIFO for any depth >= 2, with show-ahead read data, flush and sticky error flags.
// Watermark flags are built only when FIFO_SYNC_BUF_WM_EN is defined; otherwise they are tied low.
module fifo_sync_buf #(
  parameter int BITS     = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [BITS-1:0]              data_in,
  output logic [BITS-1:0]              data_out,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         pndng,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_buf: DEPTH must be at least 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_buf: AF_LEVEL must be within 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_buf: AE_LEVEL must be within 0..DEPTH-1");
  end

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic [CW-1:0]   count_q, count_next;
  logic            is_full, is_empty, do_push, do_pop;
  logic            overflow_q, underflow_q;

  // push/pop are request strobes with no ready: a push is taken when not full
  // (or when paired with a pop), a pop when not empty; rejected ones set the sticky flags.
  assign is_full  = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign do_push  = push & (~is_full | pop);
  assign do_pop   = pop & ~is_empty;

  // Explicit compare so non-power-of-two depths wrap correctly.
  assign wr_ptr_inc = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_inc = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

  always_comb begin
    count_next = count_q;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count_next = count_q + 1'b1;
        2'b01:   count_next = count_q - 1'b1;
        default: count_next = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_next;
      if (flush) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr_inc;
        if (do_pop)  rd_ptr <= rd_ptr_inc;
        if (push && is_full && !pop) overflow_q  <= 1'b1;
        if (pop && is_empty)         underflow_q <= 1'b1;
      end
    end
  end

  // Storage is deliberately left unreset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= data_in;
  end

  assign data_out  = is_empty ? '0 : mem[rd_ptr];
  assign count     = count_q;
  assign full      = is_full;
  assign pndng     = ~is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

`ifdef FIFO_SYNC_BUF_WM_EN
  logic af_q, ae_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_q <= 1'b0;
      ae_q <= 1'b1;
    end else begin
      af_q <= (count_next >= CW'(AF_LEVEL));
      ae_q <= (count_next <= CW'(AE_LEVEL));
    end
  end

  assign almost_full  = af_q;
  assign almost_empty = ae_q;
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_buf.sv
// Directed bench for fifo_sync_buf: vector table on a DEPTH=4 instance, wrap sequence on DEPTH=5.
module tb_fifo_sync_buf;

`ifdef FIFO_SYNC_BUF_WM_EN
  localparam bit WM = 1'b1;
`else
  localparam bit WM = 1'b0;
`endif

  typedef struct {
    logic       push, pop, flush;
    logic [3:0] din;
    int         cnt;
    logic       full, pndng;
    logic [3:0] dout;
    logic       ovf, udf, ae, af;
  } vec_t;

  vec_t vecs[$];
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int b_cnt    = 0;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  initial forever #5 clk = ~clk;

  logic       push_a, pop_a, flush_a;
  logic [3:0] din_a, dout_a;
  logic [2:0] cnt_a;
  logic       full_a, pndng_a, af_a, ae_a, ovf_a, udf_a;

  logic       push_b, pop_b, flush_b;
  logic [3:0] din_b, dout_b;
  logic [2:0] cnt_b;
  logic       full_b, pndng_b, af_b, ae_b, ovf_b, udf_b;

  fifo_sync_buf #(.BITS(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .clk(clk), .rst(rst), .push(push_a), .pop(pop_a), .flush(flush_a),
    .data_in(din_a), .data_out(dout_a), .count(cnt_a), .full(full_a),
    .pndng(pndng_a), .almost_full(af_a), .almost_empty(ae_a),
    .overflow(ovf_a), .underflow(udf_a)
  );

  fifo_sync_buf #(.BITS(4), .DEPTH(5)) dut_b (
    .clk(clk), .rst(rst), .push(push_b), .pop(pop_b), .flush(flush_b),
    .data_in(din_b), .data_out(dout_b), .count(cnt_b), .full(full_b),
    .pndng(pndng_b), .almost_full(af_b), .almost_empty(ae_b),
    .overflow(ovf_b), .underflow(udf_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic p, q, f, input logic [3:0] d, input int c,
                              input logic fu, pn, input logic [3:0] dq,
                              input logic o, u, ae, af);
    vec_t v;
    v.push = p; v.pop = q; v.flush = f; v.din = d; v.cnt = c;
    v.full = fu; v.pndng = pn; v.dout = dq; v.ovf = o; v.udf = u; v.ae = ae; v.af = af;
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic apply_a(input logic p, q, f, input logic [3:0] d);
    @(negedge clk);
    push_a = p; pop_a = q; flush_a = f; din_a = d;
    @(posedge clk);
    #1;
  endtask

  task automatic b_op(input logic p, q, input logic [3:0] d);
    @(negedge clk);
    if (q) begin
      if (exp_q.size() == 0) check("b model empty", 32'd1, 32'd0);
      else check("b pop data", {28'd0, dout_b}, {28'd0, exp_q.pop_front()});
      b_cnt--;
    end
    if (p) begin
      exp_q.push_back(d);
      b_cnt++;
    end
    push_b = p; pop_b = q; din_b = d;
    @(posedge clk);
    #1;
    check("b count", {29'd0, cnt_b}, b_cnt);
    check("b wr_ptr range", {31'd0, (dut_b.wr_ptr < 3'd5)}, 32'd1);
  endtask

  task automatic check_a(input string tag, input vec_t v);
    check({tag, " count"}, {29'd0, cnt_a}, v.cnt);
    check({tag, " full"}, {31'd0, full_a}, {31'd0, v.full});
    check({tag, " pndng"}, {31'd0, pndng_a}, {31'd0, v.pndng});
    check({tag, " data_out"}, {28'd0, dout_a}, {28'd0, v.dout});
    check({tag, " overflow"}, {31'd0, ovf_a}, {31'd0, v.ovf});
    check({tag, " underflow"}, {31'd0, udf_a}, {31'd0, v.udf});
    check({tag, " almost_empty"}, {31'd0, ae_a}, {31'd0, v.ae & WM});
    check({tag, " almost_full"}, {31'd0, af_a}, {31'd0, v.af & WM});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    rst = 1'b1;
    push_a = 0; pop_a = 0; flush_a = 0; din_a = '0;
    push_b = 0; pop_b = 0; flush_b = 0; din_b = '0;
    #3;
    rv = '{push:0, pop:0, flush:0, din:0, cnt:0, full:0, pndng:0, dout:0, ovf:0, udf:0, ae:1, af:0};
    check_a("in reset", rv);
    #5 rst = 1'b0;

    // p  q  f  din    cnt fu pn dout ovf udf ae af
    add(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 4'h1, 1, 0, 1, 4'h1, 0, 0, 1, 0);
    add(1, 0, 0, 4'h2, 2, 0, 1, 4'h1, 0, 0, 0, 0);
    add(1, 0, 0, 4'h3, 3, 0, 1, 4'h1, 0, 0, 0, 1);
    add(1, 0, 0, 4'h4, 4, 1, 1, 4'h1, 0, 0, 0, 1);
    add(1, 0, 0, 4'h5, 4, 1, 1, 4'h1, 1, 0, 0, 1);
    add(0, 1, 0, 4'h0, 3, 0, 1, 4'h2, 1, 0, 0, 1);
    add(0, 1, 0, 4'h0, 2, 0, 1, 4'h3, 1, 0, 0, 0);
    add(0, 1, 0, 4'h0, 1, 0, 1, 4'h4, 1, 0, 1, 0);
    add(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 1, 0, 1, 0);
    add(0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 1, 0, 4'hA, 1, 0, 1, 4'hA, 0, 1, 1, 0);
    add(1, 0, 0, 4'h1, 2, 0, 1, 4'hA, 0, 1, 0, 0);
    add(1, 0, 0, 4'h2, 3, 0, 1, 4'hA, 0, 1, 0, 1);
    add(1, 0, 0, 4'h3, 4, 1, 1, 4'hA, 0, 1, 0, 1);
    add(1, 1, 0, 4'hB, 4, 1, 1, 4'h1, 0, 1, 0, 1);
    add(0, 1, 0, 4'h0, 3, 0, 1, 4'h2, 0, 1, 0, 1);
    add(0, 1, 0, 4'h0, 2, 0, 1, 4'h3, 0, 1, 0, 0);
    add(0, 1, 0, 4'h0, 1, 0, 1, 4'hB, 0, 1, 1, 0);
    add(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    add(1, 0, 0, 4'h4, 1, 0, 1, 4'h4, 0, 1, 1, 0);
    add(1, 0, 0, 4'h5, 2, 0, 1, 4'h4, 0, 1, 0, 0);
    add(1, 0, 0, 4'h6, 3, 0, 1, 4'h4, 0, 1, 0, 1);
    add(1, 0, 0, 4'h7, 4, 1, 1, 4'h4, 0, 1, 0, 1);
    add(1, 0, 0, 4'h8, 4, 1, 1, 4'h4, 1, 1, 0, 1);
    add(0, 1, 0, 4'h0, 3, 0, 1, 4'h5, 1, 1, 0, 1);
    add(1, 0, 1, 4'hC, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(1, 0, 0, 4'h9, 1, 0, 1, 4'h9, 0, 0, 1, 0);
    add(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
    add(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
    add(0, 0, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      apply_a(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
      check_a($sformatf("v%0d", i), vecs[i]);
    end

    // DEPTH=5: pointers wrap 4 -> 0, pop order must be 0..6
    for (int i = 0; i < 7; i++) b_op(1'b1, (b_cnt == 5), 4'(i));
    for (int k = 0; k < 10 && b_cnt > 0; k++) b_op(1'b0, 1'b1, 4'h0);
    check("b drained pndng", {31'd0, pndng_b}, 32'd0);
    check("b drained data_out", {28'd0, dout_b}, 32'd0);
    check("b no underflow", {31'd0, udf_b}, 32'd0);
    check("b no overflow", {31'd0, ovf_b}, 32'd0);

    // Fill A past full, then assert rst between clock edges
    for (int i = 1; i <= 5; i++) apply_a(1'b1, 1'b0, 1'b0, 4'(i));
    apply_a(1'b0, 1'b0, 1'b0, 4'h0);
    check("pre-rst count", {29'd0, cnt_a}, 32'd4);
    check("pre-rst overflow", {31'd0, ovf_a}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    rv = '{push:0, pop:0, flush:0, din:0, cnt:0, full:0, pndng:0, dout:0, ovf:0, udf:0, ae:1, af:0};
    check_a("async rst", rv);
    @(negedge clk);
    rst = 1'b0;
    apply_a(1'b0, 1'b0, 1'b0, 4'h0);
    check_a("post rst idle", rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
